// File: rtl/divider_alu_pkg.sv
// rtl/divider_alu_pkg.sv - shared widths, FSM state encodings and HI/LO packing offsets
package divider_alu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_ITER = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    // {HI, LO} layout shared with the multiplier result path
    localparam int HI_LSB = DATA_WIDTH;
    localparam int LO_LSB = 0;

endpackage

// File: rtl/divider_alu_div_step.sv
// rtl/divider_alu_div_step.sv - one radix-2 non-restoring shift and add-or-subtract step
module div_step
    import divider_alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic signed [WIDTH:0]   r,
    input  logic        [WIDTH-1:0] q,
    input  logic signed [WIDTH:0]   d,
    output logic signed [WIDTH:0]   r_next,
    output logic        [WIDTH-1:0] q_next
);

    logic signed [WIDTH:0] r_shift;

    // Shifting never changes the sign of a partial remainder in [-D, D), so the pre-shift sign steers the op.
    always_comb begin
        r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
        r_next  = r[WIDTH] ? r_shift + d : r_shift - d;
        q_next  = {q[WIDTH-2:0], ~r_next[WIDTH]};
    end

endmodule

// File: rtl/divider_alu.sv
// rtl/divider_alu.sv - sequential signed divider returning {remainder, quotient}
module divider_alu
    import divider_alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]              state;
    logic [CW-1:0]           counter;
    logic                    sign_q;
    logic                    sign_r;
    logic                    zero_div;
    logic signed [WIDTH:0]   rem_r;
    logic signed [WIDTH:0]   div_d;
    logic [WIDTH-1:0]        quo_q;

    logic signed [WIDTH:0]   r_next;
    logic [WIDTH-1:0]        q_next;
    logic [WIDTH-1:0]        a_abs;
    logic signed [WIDTH:0]   b_ext;
    logic signed [WIDTH:0]   b_abs;
    logic [WIDTH-1:0]        r_fixed;
    logic [WIDTH-1:0]        quotient;
    logic [WIDTH-1:0]        remainder;
    logic [WIDTH-1:0]        dividend;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .r      (rem_r),
        .q      (quo_q),
        .d      (div_d),
        .r_next (r_next),
        .q_next (q_next)
    );

    // |a| fits WIDTH unsigned bits even for the most negative value; D needs the extra bit.
    always_comb begin
        a_abs     = a[WIDTH-1] ? -a : a;
        b_ext     = {b[WIDTH-1], b};
        b_abs     = b_ext[WIDTH] ? -b_ext : b_ext;
        r_fixed   = rem_r[WIDTH] ? rem_r[WIDTH-1:0] + div_d[WIDTH-1:0] : rem_r[WIDTH-1:0];
        quotient  = sign_q ? -quo_q : quo_q;
        remainder = sign_r ? -r_fixed : r_fixed;
        dividend  = sign_r ? -quo_q : quo_q;
    end

    assign busy = (state == DIV_ITER) || (state == DIV_FIX);
    assign done = (state == DIV_DONE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= DIV_IDLE;
            z           <= '0;
            div_by_zero <= 1'b0;
            counter     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_div    <= 1'b0;
            rem_r       <= '0;
            div_d       <= '0;
            quo_q       <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r   <= a[WIDTH-1];
                        quo_q    <= a_abs;
                        div_d    <= b_abs;
                        rem_r    <= '0;
                        counter  <= CW'(WIDTH);
                        zero_div <= (b == '0);
                        // A zero divisor skips the iterations; FIX still packs the result.
                        state    <= (b == '0) ? DIV_FIX : DIV_ITER;
                    end
                end
                DIV_ITER: begin
                    rem_r   <= r_next;
                    quo_q   <= q_next;
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    z           <= zero_div ? {dividend, {WIDTH{1'b1}}} : {remainder, quotient};
                    div_by_zero <= zero_div;
                    state       <= DIV_DONE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule
